// File: rtl/lda_arb_pkg.sv
// Shared types and defaults for the line-drawing-algorithm arbiter.
// The state enum, default command field widths and flattened-bus slice helper.
package lda_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_LOW = 3'd2,
    ST_BUSY     = 3'd3,
    ST_ACK      = 3'd4
  } state_t;

  localparam int DEF_X_W = 9;
  localparam int DEF_Y_W = 8;
  localparam int DEF_C_W = 3;

  // Low bit of requester idx's field in a flattened per-requester bus.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/lda_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);
  localparam int IW = $clog2(N);

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N);
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[wrap(int'(ptr) + i)]) begin
        valid                      = 1'b1;
        idx                        = wrap(int'(ptr) + i);
        gnt[wrap(int'(ptr) + i)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lda_arbiter.sv
// Shares one line_drawing_algorithm between N_REQ requesters: round-robin pick,
// latch the winner's command, pulse start, wait for done, then ack the winner.
module lda_arbiter
  import lda_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int C_W   = DEF_C_W
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*X_W-1:0]       i_x0,
  input  logic [N_REQ*X_W-1:0]       i_x1,
  input  logic [N_REQ*Y_W-1:0]       i_y0,
  input  logic [N_REQ*Y_W-1:0]       i_y1,
  input  logic [N_REQ*C_W-1:0]       i_color,
  input  logic                       i_done,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [N_REQ-1:0]           o_ack,
  output logic [$clog2(N_REQ)-1:0]   o_owner,
  output logic                       o_busy,
  output logic [X_W-1:0]             o_x0,
  output logic [X_W-1:0]             o_x1,
  output logic [Y_W-1:0]             o_y0,
  output logic [Y_W-1:0]             o_y1,
  output logic [C_W-1:0]             o_color,
  output logic                       o_start
);
  localparam int IW = $clog2(N_REQ);

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [N_REQ-1:0] gnt_n, ack_n;
  logic [IW-1:0]    owner_n;
  logic             busy_n, start_n;
  logic [X_W-1:0]   x0_n, x1_n;
  logic [Y_W-1:0]   y0_n, y1_n;
  logic [C_W-1:0]   color_n;

  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_vld;

  logic [X_W-1:0] x0_a    [N_REQ];
  logic [X_W-1:0] x1_a    [N_REQ];
  logic [Y_W-1:0] y0_a    [N_REQ];
  logic [Y_W-1:0] y1_a    [N_REQ];
  logic [C_W-1:0] color_a [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign x0_a[k]    = i_x0[slice_lo(k, X_W) +: X_W];
    assign x1_a[k]    = i_x1[slice_lo(k, X_W) +: X_W];
    assign y0_a[k]    = i_y0[slice_lo(k, Y_W) +: Y_W];
    assign y1_a[k]    = i_y1[slice_lo(k, Y_W) +: Y_W];
    assign color_a[k] = i_color[slice_lo(k, C_W) +: C_W];
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (i_req),
    .ptr   (ptr),
    .gnt   (win_oh),
    .idx   (win_idx),
    .valid (win_vld)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = o_gnt;
    ack_n   = '0;
    owner_n = o_owner;
    busy_n  = o_busy;
    start_n = 1'b0;
    x0_n    = o_x0;
    x1_n    = o_x1;
    y0_n    = o_y0;
    y1_n    = o_y1;
    color_n = o_color;
    case (state)
      ST_IDLE: begin
        if (win_vld) begin
          state_n = ST_START;
          gnt_n   = win_oh;
          owner_n = win_idx;
          busy_n  = 1'b1;
          start_n = 1'b1;
          x0_n    = x0_a[win_idx];
          x1_n    = x1_a[win_idx];
          y0_n    = y0_a[win_idx];
          y1_n    = y1_a[win_idx];
          color_n = color_a[win_idx];
          ptr_n   = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      ST_START:    state_n = ST_WAIT_LOW;
      // A done level left high by the previous line must drop before it counts.
      ST_WAIT_LOW: if (!i_done) state_n = ST_BUSY;
      ST_BUSY: begin
        if (i_done) begin
          state_n = ST_ACK;
          ack_n   = o_gnt;
        end
      end
      ST_ACK: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        owner_n = '0;
        busy_n  = 1'b0;
        x0_n    = '0;
        x1_n    = '0;
        y0_n    = '0;
        y1_n    = '0;
        color_n = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      o_gnt   <= '0;
      o_ack   <= '0;
      o_owner <= '0;
      o_busy  <= 1'b0;
      o_start <= 1'b0;
      o_x0    <= '0;
      o_x1    <= '0;
      o_y0    <= '0;
      o_y1    <= '0;
      o_color <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      o_gnt   <= gnt_n;
      o_ack   <= ack_n;
      o_owner <= owner_n;
      o_busy  <= busy_n;
      o_start <= start_n;
      o_x0    <= x0_n;
      o_x1    <= x1_n;
      o_y0    <= y0_n;
      o_y1    <= y1_n;
      o_color <= color_n;
    end
  end

endmodule

// File: tb/tb_lda_arbiter.sv
// Directed bench for lda_arbiter: job-level reference model compared every cycle,
// plus literal expectations for reset, single request, fairness, stale done and drops.
module tb_lda_arbiter;
  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N-1:0]    i_req;
  logic [N*XW-1:0] i_x0, i_x1;
  logic [N*YW-1:0] i_y0, i_y1;
  logic [N*CW-1:0] i_color;
  logic            i_done;
  logic [N-1:0]    o_gnt, o_ack;
  logic [1:0]      o_owner;
  logic            o_busy, o_start;
  logic [XW-1:0]   o_x0, o_x1;
  logic [YW-1:0]   o_y0, o_y1;
  logic [CW-1:0]   o_color;

  always #5 clk = ~clk;

  lda_arbiter #(.N_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req),
    .i_x0(i_x0), .i_x1(i_x1), .i_y0(i_y0), .i_y1(i_y1), .i_color(i_color),
    .i_done(i_done), .o_gnt(o_gnt), .o_ack(o_ack), .o_owner(o_owner),
    .o_busy(o_busy), .o_x0(o_x0), .o_x1(o_x1), .o_y0(o_y0), .o_y1(o_y1),
    .o_color(o_color), .o_start(o_start)
  );

  // Reference model: one job at a time, tracked as flags on the current job.
  bit            m_job, m_start, m_low, m_ack;
  int            m_owner, m_ptr, mk;
  logic [XW-1:0] m_x0, m_x1;
  logic [YW-1:0] m_y0, m_y1;
  logic [CW-1:0] m_c;

  always @(posedge clk) begin
    if (!i_reset) begin
      m_job = 0; m_start = 0; m_low = 0; m_ack = 0; m_owner = 0; m_ptr = 0;
      m_x0 = '0; m_x1 = '0; m_y0 = '0; m_y1 = '0; m_c = '0;
    end else if (m_ack) begin
      m_ack = 0; m_job = 0;
    end else if (!m_job) begin
      for (int i = 0; i < N; i++) begin
        mk = (m_ptr + i) % N;
        if (!m_job && i_req[mk]) begin
          m_job = 1; m_start = 1; m_low = 0; m_owner = mk;
          m_x0 = i_x0[mk*XW +: XW]; m_x1 = i_x1[mk*XW +: XW];
          m_y0 = i_y0[mk*YW +: YW]; m_y1 = i_y1[mk*YW +: YW];
          m_c  = i_color[mk*CW +: CW];
          m_ptr = (mk + 1) % N;
        end
      end
    end else if (m_start) begin
      m_start = 0;
    end else if (!m_low) begin
      if (!i_done) m_low = 1;
    end else if (i_done) begin
      m_ack = 1;
    end
  end

  int n_run = 0, n_fail = 0;
  int cyc = 0;
  bit auto_rereq = 0;
  logic [N-1:0] pend = '0;
  int lda_len = 3, stale_hold = 0, stale_cnt = 0, lda_cnt = 0;
  int t_rise = -1, t_ack = -1, ack_cnt = 0;
  int starts[$];
  int fair_exp[5] = '{0, 1, 2, 3, 0};

  function automatic logic [N-1:0] oh(input bit en, input int k);
    return en ? (N'(1) << k) : '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare against the model, then act as requesters and as the LDA.
  task automatic step();
    @(negedge clk);
    cyc++;
    check("gnt",   o_gnt,   oh(m_job, m_owner));
    check("ack",   o_ack,   oh(m_ack, m_owner));
    check("owner", o_owner, m_owner);
    check("busy",  o_busy,  m_job);
    check("start", o_start, m_start);
    check("cmd", {o_x0, o_x1, o_y0, o_y1, o_color}, {m_x0, m_x1, m_y0, m_y1, m_c});
    if (o_start) starts.push_back(int'(o_owner));
    if (o_ack != '0) begin
      ack_cnt++;
      if (t_ack < 0) t_ack = cyc;
    end
    if (auto_rereq) i_req |= pend;
    pend = '0;
    if (o_ack != '0) begin
      i_req &= ~o_ack;
      pend = o_ack;
    end
    if (!i_reset) begin
      i_done = 0; stale_cnt = 0; lda_cnt = 0;
    end else if (o_start) begin
      lda_cnt = lda_len; stale_cnt = stale_hold;
      if (stale_hold == 0) i_done = 0;
    end else if (stale_cnt > 0) begin
      stale_cnt--;
      if (stale_cnt == 0) i_done = 0;
    end else if (lda_cnt > 0) begin
      lda_cnt--;
      if (lda_cnt == 0) begin i_done = 1; t_rise = cyc; end
    end
  endtask

  task automatic wait_ack(input string name, input int max);
    int i;
    i = 0;
    while (o_ack == '0 && i < max) begin step(); i++; end
    check(name, o_ack != '0, 1'b1);
  endtask

  task automatic wait_start(input string name, input int max);
    int i;
    i = 0;
    while (!o_start && i < max) begin step(); i++; end
    check(name, o_start, 1'b1);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (o_busy && i < 100) begin step(); i++; end
    check(name, o_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 0; i_req = '1; i_done = 0;
    for (int k = 0; k < N; k++) begin
      i_x0[k*XW +: XW] = XW'(k * 10 + 1);
      i_x1[k*XW +: XW] = XW'(k * 10 + 2);
      i_y0[k*YW +: YW] = YW'(k * 10 + 3);
      i_y1[k*YW +: YW] = YW'(k * 10 + 4);
      i_color[k*CW +: CW] = CW'(k + 1);
    end

    // Reset held two cycles with all requests up.
    step(); step();
    check("rst_gnt", o_gnt, 0);    check("rst_ack", o_ack, 0);
    check("rst_busy", o_busy, 0);  check("rst_start", o_start, 0);
    check("rst_owner", o_owner, 0);
    check("rst_cmd", {o_x0, o_x1, o_y0, o_y1, o_color}, 0);
    i_reset = 1;
    step();
    check("first_gnt", o_gnt, 4'b0001);
    check("first_start", o_start, 1);
    wait_ack("first_ack_seen", 50);
    i_req = '0;
    step(); drain("first_drain");

    // Single request from requester 2.
    i_req = 4'b0100;
    i_x0[2*XW +: XW] = 9'd10;  i_x1[2*XW +: XW] = 9'd100;
    i_y0[2*YW +: YW] = 8'd20;  i_y1[2*YW +: YW] = 8'd50;
    i_color[2*CW +: CW] = 3'b101;
    step();
    check("single_gnt", o_gnt, 4'b0100);
    check("single_x0", o_x0, 10);  check("single_x1", o_x1, 100);
    check("single_y0", o_y0, 20);  check("single_y1", o_y1, 50);
    check("single_color", o_color, 5);
    check("single_start", o_start, 1);
    check("single_owner", o_owner, 2);
    step();
    check("single_start_pulse", o_start, 0);
    wait_ack("single_ack_seen", 50);
    check("single_ack", o_ack, 4'b0100);
    step();
    check("single_ack_pulse", o_ack, 0);
    check("single_idle", o_busy, 0);

    // Fairness from a fresh pointer, every requester re-requesting after ack.
    i_reset = 0; step(); i_reset = 1;
    i_req = '1; auto_rereq = 1; starts.delete();
    for (int i = 0; i < 200 && starts.size() < 5; i++) step();
    check("fair_count", starts.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < starts.size()) check("fair_order", starts[i], fair_exp[i]);
    auto_rereq = 0; pend = '0; i_req = '0;
    wait_ack("fair_last_ack", 50);
    step(); drain("fair_drain");

    // Stale done: LDA keeps done high for three cycles after start.
    stale_hold = 3; t_rise = -1; t_ack = -1;
    i_req = 4'b0010;
    wait_ack("stale_ack_seen", 60);
    check("stale_gap", t_ack - t_rise, 1);
    stale_hold = 0;
    step(); drain("stale_drain");

    // Reset while BUSY, with requester 3 waiting.
    lda_len = 20; i_req = 4'b0001;
    wait_start("rb_start", 20);
    step(); step(); step();
    check("rb_busy_before", o_busy, 1);
    i_req = 4'b1000; i_reset = 0;
    step();
    check("rb_gnt", o_gnt, 0);    check("rb_busy", o_busy, 0);
    check("rb_start", o_start, 0); check("rb_ack", o_ack, 0);
    i_reset = 1; lda_len = 3;
    step();
    check("rb_regrant", o_gnt, 4'b1000);
    wait_ack("rb_ack_seen", 50);
    step(); drain("rb_drain");

    // Requester 1 drops its request mid-line.
    lda_len = 5; i_req = 4'b0010; starts.delete(); ack_cnt = 0;
    wait_start("drop_start", 20);
    step(); step(); step();
    i_req = '0;
    for (int i = 0; i < 30; i++) step();
    check("drop_acks", ack_cnt, 1);
    check("drop_grants", starts.size(), 1);
    check("drop_idle", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
